// File: rtl/mandelbrot_pkg.sv
// Shared constants, fixed-point helpers and FSM state type for the Mandelbrot engine.
package mandelbrot_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int FRAC_DEF   = 12;
   localparam int ITER_W_DEF = 8;

   // |z|^2 escape threshold (4.0) at full product width plus one guard bit
   localparam logic [2*DATA_W_DEF:0] ESCAPE_R2 = (2*DATA_W_DEF+1)'(4) << (2*FRAC_DEF);

   localparam logic [DATA_W_DEF-1:0] ONE = DATA_W_DEF'(1) << FRAC_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mandelbrot_step.sv
// One combinational z <- z^2 + c step plus the |z|^2 >= 4 escape test on the current z.
module mandelbrot_step
   import mandelbrot_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FRAC   = FRAC_DEF
) (
   input  logic signed [DATA_W-1:0] zr_i,
   input  logic signed [DATA_W-1:0] zi_i,
   input  logic signed [DATA_W-1:0] cr_i,
   input  logic signed [DATA_W-1:0] ci_i,
   output logic signed [DATA_W-1:0] next_zr_o,
   output logic signed [DATA_W-1:0] next_zi_o,
   output logic                     escape_o
);

   localparam logic signed [2*DATA_W:0] ESC_THRESH = (2*DATA_W+1)'(4) << (2*FRAC);

   logic signed [2*DATA_W-1:0] zr_w;
   logic signed [2*DATA_W-1:0] zi_w;
   logic signed [2*DATA_W-1:0] sq_r;
   logic signed [2*DATA_W-1:0] sq_i;
   logic signed [2*DATA_W-1:0] prod_ri;
   logic signed [2*DATA_W:0]   mag;
   logic signed [2*DATA_W:0]   diff;
   logic signed [2*DATA_W:0]   dbl;

   always_comb begin
      zr_w    = {{DATA_W{zr_i[DATA_W-1]}}, zr_i};
      zi_w    = {{DATA_W{zi_i[DATA_W-1]}}, zi_i};
      sq_r    = zr_w * zr_w;
      sq_i    = zi_w * zi_w;
      prod_ri = zr_w * zi_w;
      // One guard bit keeps the sum, difference and doubling exact
      mag     = {sq_r[2*DATA_W-1], sq_r} + {sq_i[2*DATA_W-1], sq_i};
      diff    = {sq_r[2*DATA_W-1], sq_r} - {sq_i[2*DATA_W-1], sq_i};
      dbl     = {prod_ri, 1'b0};
   end

   // Floor shift back to the Q format, then wrap to DATA_W before adding c
   assign next_zr_o = DATA_W'(diff >>> FRAC) + cr_i;
   assign next_zi_o = DATA_W'(dbl >>> FRAC) + ci_i;
   assign escape_o  = (mag >= ESC_THRESH);

endmodule

// File: rtl/mandelbrot_iter.sv
// Per-pixel Mandelbrot engine: accepts one point, iterates until escape or limit, holds result.
module mandelbrot_iter
   import mandelbrot_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FRAC   = FRAC_DEF,
   parameter int ITER_W = ITER_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_cr,
   input  logic [DATA_W-1:0] i_ci,
   input  logic [ITER_W-1:0] i_max_iter,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [ITER_W-1:0] o_iter,
   output logic              o_escaped,
   output logic              o_busy
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; o_ready is high only in IDLE, o_valid only in DONE, and the
   // DONE->IDLE edge never doubles as an accept.

   state_e state_q, state_d;

   logic signed [DATA_W-1:0] cr_q, cr_d;
   logic signed [DATA_W-1:0] ci_q, ci_d;
   logic signed [DATA_W-1:0] zr_q, zr_d;
   logic signed [DATA_W-1:0] zi_q, zi_d;
   logic [ITER_W-1:0]        max_q, max_d;
   logic [ITER_W-1:0]        n_q, n_d;
   logic                     esc_q, esc_d;

   logic signed [DATA_W-1:0] next_zr;
   logic signed [DATA_W-1:0] next_zi;
   logic                     step_escape;

   mandelbrot_step #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC)
   ) u_step (
      .zr_i      (zr_q),
      .zi_i      (zi_q),
      .cr_i      (cr_q),
      .ci_i      (ci_q),
      .next_zr_o (next_zr),
      .next_zi_o (next_zi),
      .escape_o  (step_escape)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cr_q    <= '0;
         ci_q    <= '0;
         zr_q    <= '0;
         zi_q    <= '0;
         max_q   <= '0;
         n_q     <= '0;
         esc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cr_q    <= cr_d;
         ci_q    <= ci_d;
         zr_q    <= zr_d;
         zi_q    <= zi_d;
         max_q   <= max_d;
         n_q     <= n_d;
         esc_q   <= esc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cr_d    = cr_q;
      ci_d    = ci_q;
      zr_d    = zr_q;
      zi_d    = zi_q;
      max_d   = max_q;
      n_d     = n_q;
      esc_d   = esc_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               cr_d    = i_cr;
               ci_d    = i_ci;
               max_d   = i_max_iter;
               zr_d    = '0;
               zi_d    = '0;
               n_d     = '0;
               esc_d   = 1'b0;
               state_d = ITER;
            end
         end
         ITER: begin
            // Escape test wins over the limit test in the same cycle
            if (step_escape) begin
               esc_d   = 1'b1;
               state_d = DONE;
            end else if (n_q == max_q) begin
               esc_d   = 1'b0;
               state_d = DONE;
            end else begin
               zr_d = next_zr;
               zi_d = next_zi;
               n_d  = n_q + ITER_W'(1);
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The three status outputs are a one-hot view of the FSM state
   assign o_ready   = (state_q == IDLE);
   assign o_busy    = (state_q == ITER);
   assign o_valid   = (state_q == DONE);
   assign o_iter    = n_q;
   assign o_escaped = esc_q;

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Directed-vector bench for mandelbrot_iter: result table plus backpressure and reset sequences.
module tb_mandelbrot_iter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_cr;
   logic [15:0] i_ci;
   logic [7:0]  i_max_iter;
   logic        o_valid;
   logic        i_ready;
   logic [7:0]  o_iter;
   logic        o_escaped;
   logic        o_busy;

   int n_vec  = 0;
   int n_miss = 0;

   mandelbrot_iter dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_cr       (i_cr),
      .i_ci       (i_ci),
      .i_max_iter (i_max_iter),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_iter     (o_iter),
      .o_escaped  (o_escaped),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0] cr;
      logic [15:0] ci;
      logic [7:0]  max_it;
      logic [7:0]  exp_iter;
      logic        exp_esc;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Present a point while in IDLE; returns just after the accepting edge (cycle 1)
   task automatic send_point(input logic [15:0] cr, input logic [15:0] ci, input logic [7:0] mx);
      i_cr       = cr;
      i_ci       = ci;
      i_max_iter = mx;
      i_valid    = 1'b1;
      step();
      i_valid    = 1'b0;
   endtask

   // Called in cycle 1; returns the cycle number in which o_valid was first seen
   task automatic wait_result(input int budget, output int cyc);
      cyc = 1;
      while (!o_valid && cyc < budget) begin
         step();
         cyc++;
      end
   endtask

   task automatic release_result();
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
   endtask

   initial begin
      int cyc;
      int bad;
      logic [7:0] held_iter;
      logic       held_esc;

      vecs[0]  = '{16'h0000, 16'h0000, 8'd255, 8'd255, 1'b0};
      vecs[1]  = '{16'h2000, 16'h0000, 8'd255, 8'd1,   1'b1};
      vecs[2]  = '{16'h0800, 16'h0000, 8'd50,  8'd5,   1'b1};
      vecs[3]  = '{16'hF000, 16'h0000, 8'd10,  8'd10,  1'b0};
      vecs[4]  = '{16'h0400, 16'h0800, 8'd0,   8'd0,   1'b0};
      vecs[5]  = '{16'h0000, 16'h2000, 8'd255, 8'd1,   1'b1};
      vecs[6]  = '{16'hE000, 16'h0000, 8'd100, 8'd1,   1'b1};
      vecs[7]  = '{16'h1000, 16'h0000, 8'd20,  8'd2,   1'b1};
      vecs[8]  = '{16'h0000, 16'h1000, 8'd8,   8'd8,   1'b0};
      vecs[9]  = '{16'h0400, 16'h0000, 8'd20,  8'd20,  1'b0};
      vecs[10] = '{16'h0000, 16'hF000, 8'd7,   8'd7,   1'b0};

      i_rst      = 1'b1;
      i_valid    = 1'b0;
      i_ready    = 1'b0;
      i_cr       = '0;
      i_ci       = '0;
      i_max_iter = '0;
      repeat (3) step();
      i_rst = 1'b0;

      check("reset_ready",   o_ready,   1);
      check("reset_valid",   o_valid,   0);
      check("reset_iter",    o_iter,    0);
      check("reset_escaped", o_escaped, 0);
      check("reset_busy",    o_busy,    0);

      for (int i = 0; i < NVEC; i++) begin
         send_point(vecs[i].cr, vecs[i].ci, vecs[i].max_it);
         check($sformatf("v%0d_busy_c1", i),  {o_busy, o_ready}, 2'b10);
         wait_result(400, cyc);
         check($sformatf("v%0d_valid", i),   o_valid,   1);
         check($sformatf("v%0d_iter", i),    o_iter,    vecs[i].exp_iter);
         check($sformatf("v%0d_escaped", i), o_escaped, vecs[i].exp_esc);
         check($sformatf("v%0d_latency", i), cyc,       int'(vecs[i].exp_iter) + 2);
         release_result();
         check($sformatf("v%0d_after_xfer", i), {o_valid, o_ready}, 2'b01);
      end

      // Backpressure: result must hold for 20 cycles and new points must be ignored
      send_point(16'h0800, 16'h0000, 8'd50);
      wait_result(400, cyc);
      check("bp_valid", o_valid, 1);
      held_iter = o_iter;
      held_esc  = o_escaped;
      check("bp_iter", held_iter, 5);
      i_cr       = 16'h2000;
      i_ci       = 16'h0000;
      i_max_iter = 8'd3;
      i_valid    = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (o_iter !== held_iter || o_escaped !== held_esc || o_valid !== 1'b1 ||
             o_ready !== 1'b0 || o_busy !== 1'b0)
            bad++;
      end
      check("bp_hold_bad_cycles", bad, 0);
      release_result();
      check("bp_xfer_no_accept", {o_valid, o_ready, o_busy}, 3'b010);
      step();
      i_valid = 1'b0;
      check("bp_next_accept_busy", o_busy, 1);
      wait_result(400, cyc);
      check("bp_next_iter",    o_iter,    1);
      check("bp_next_escaped", o_escaped, 1);
      check("bp_next_latency", cyc,       3);
      release_result();

      // Reset during ITER discards the in-flight point
      send_point(16'h0000, 16'h0000, 8'd255);
      repeat (49) step();
      check("rst_mid_busy", o_busy, 1);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      check("rst_mid_state", {o_valid, o_ready, o_busy}, 3'b010);
      check("rst_mid_iter",  o_iter, 0);
      send_point(16'h2000, 16'h0000, 8'd255);
      wait_result(400, cyc);
      check("rst_after_iter",    o_iter,    1);
      check("rst_after_escaped", o_escaped, 1);
      check("rst_after_latency", cyc,       3);

      // Reset while holding a result in DONE
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      check("rst_done_state", {o_valid, o_ready, o_busy}, 3'b010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
